cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Shares the single physical-memory port between the split instruction cache and data cache.
- Each cache's memory-side interface (read/write strobes, 16-bit line address, 128-bit line data, resp) connects here.
- The arbiter grants one cache at a time, holds the grant until physical memory answers, then re-arbitrates.
- Sits between the two cache instances and physical memory in the top-level CPU.

Parameters:
- FIXED_D_PRIORITY, 0, 0 = round-robin between caches on contention; 1 = data cache always wins contention.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_pmem_read  in  1  I-cache line-read request
- i_pmem_write  in  1  I-cache line-write request (tied low in practice, still honoured)
- i_pmem_address  in  16 (lc3b_word)  I-cache line address
- i_pmem_wdata  in  128  I-cache write line
- i_pmem_rdata  out  128  line data to I-cache
- i_pmem_resp  out  1  completion to I-cache
- d_pmem_read  in  1  D-cache line-read request
- d_pmem_write  in  1  D-cache line-write (writeback) request
- d_pmem_address  in  16  D-cache line address
- d_pmem_wdata  in  128  D-cache write line
- d_pmem_rdata  out  128  line data to D-cache
- d_pmem_resp  out  1  completion to D-cache
- pmem_read  out  1  read strobe to physical memory
- pmem_write  out  1  write strobe to physical memory
- pmem_address  out  16  address to physical memory
- pmem_wdata  out  128  write line to physical memory
- pmem_rdata  in  128  line from physical memory
- pmem_resp  in  1  physical memory completion

Behaviour:
- Requester X is pending when X_pmem_read | X_pmem_write.
- State register is one of IDLE, SERVE_I, SERVE_D.
- Last-grant register holds I or D.
- Reset values: state = IDLE, last_grant = D (so the first contention goes to I under round-robin).
- During reset, all outputs are 0.
- IDLE:
  - pmem_read, pmem_write, i_pmem_resp and d_pmem_resp are 0.
  - pmem_address and pmem_wdata are 0.
  - Next state: SERVE_I if only I is pending; SERVE_D if only D is pending.
  - Both pending: SERVE_D when FIXED_D_PRIORITY=1. Otherwise serve the requester opposite to last_grant.
  - Neither pending: stay in IDLE.
  - Arbitration costs exactly one cycle: a request seen in IDLE is forwarded to memory starting the next cycle.
- SERVE_X:
  - pmem_address and pmem_wdata are driven combinationally from X's inputs.
  - pmem_write = X_pmem_write.
  - pmem_read = X_pmem_read & ~X_pmem_write: write wins if both are asserted, and the read is masked.
  - X_pmem_resp = pmem_resp. The non-granted requester's resp is forced to 0.
  - Its requests are ignored and it simply waits.
- Completion: pmem_resp=1 in SERVE_X sets next state = IDLE and last_grant = X. Because of the mandatory IDLE cycle, the other requester is granted two cycles after the completion edge at the earliest.
- Abandoned request: in SERVE_X with X no longer pending and pmem_resp=0, go to IDLE without updating last_grant. Memory strobes drop the same cycle.
- Data routing: i_pmem_rdata = d_pmem_rdata = pmem_rdata at all times. Only the resp gating selects the consumer.
- Non-granted requester changing its inputs mid-transaction has no effect on memory-side outputs.
- rst asserted mid-transaction: state goes to IDLE on that edge and strobes drop. A pmem_resp arriving later while in IDLE is discarded and never forwarded.
- There are no internal data registers. Address and data stability during a transaction is the requesting cache's responsibility, since cache controllers hold their strobes until resp.

Decomposition:
- Add an enum arb_state_t {IDLE, SERVE_I, SERVE_D} and an arb_sel_t {SEL_I, SEL_D} to lc3b_types.
- Reuse lc3b_word for the addresses.
- Add a 128-bit line typedef lc3b_line to lc3b_types if one is not already present.
- Control and datapath are small enough for one module.
- One optional sub-module, cache_arbiter_mux: the 2:1 selection of address, wdata and strobes keyed by arb_sel_t.

Test Plan:
- Lone I read: i_pmem_read=1, address 0x1230; memory resp after 3 cycles.
  - pmem_read=1 and pmem_address=0x1230 from cycle 1 through the resp cycle.
  - i_pmem_resp pulses once; d_pmem_resp stays 0; state is IDLE after resp.
- Simultaneous requests, round-robin after reset: I read 0x0040 and D write 0x8000 raised in the same cycle.
  - I is served first.
  - D's pmem_write appears 2 cycles after I's resp, with pmem_wdata equal to D's line and d_pmem_resp pulsing.
- Round-robin alternation: both caches hold requests continuously for 4 transactions.
  - Grant order is I, D, I, D.
  - With FIXED_D_PRIORITY=1 the order is D, D, D, D while D stays pending.
- Read+write conflict: d_pmem_read=1 and d_pmem_write=1 together.
  - pmem_write=1 and pmem_read=0 throughout.
- Reset mid-operation: rst asserted 2 cycles into a D read; memory raises resp 1 cycle later.
  - All outputs are 0 the cycle after reset.
  - d_pmem_resp is never asserted.
  - A subsequent I request is served normally.
- Abandon: D read granted, then d_pmem_read drops with no resp.
  - Next cycle the state is IDLE and pmem_read=0.
  - last_grant is unchanged, so the next contention still favours D's opponent as before.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache to physical-memory arbiter.
package cache_arbiter_pkg;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
   typedef enum logic {SEL_I, SEL_D} arb_sel_t;

endpackage

// File: rtl/cache_arbiter_mux.sv
// 2:1 selection of the granted cache's address, line and strobes onto the memory side.
import cache_arbiter_pkg::*;

module cache_arbiter_mux (
   input  logic     en,
   input  arb_sel_t sel,
   input  logic     i_read,
   input  logic     i_write,
   input  lc3b_word i_address,
   input  lc3b_line i_wdata,
   input  logic     d_read,
   input  logic     d_write,
   input  lc3b_word d_address,
   input  lc3b_line d_wdata,
   output logic     read,
   output logic     write,
   output lc3b_word address,
   output lc3b_line wdata
);

   always_comb begin
      read    = 1'b0;
      write   = 1'b0;
      address = '0;
      wdata   = '0;
      if (en) begin
         // A write masks a simultaneous read from the same cache.
         unique case (sel)
            SEL_I: begin
               address = i_address;
               wdata   = i_wdata;
               write   = i_write;
               read    = i_read & ~i_write;
            end
            SEL_D: begin
               address = d_address;
               wdata   = d_wdata;
               write   = d_write;
               read    = d_read & ~d_write;
            end
         endcase
      end
   end

endmodule

// File: rtl/cache_arbiter.sv
// Grants the single physical-memory port to the I-cache or D-cache, one transaction at a time.
import cache_arbiter_pkg::*;

module cache_arbiter #(
   parameter bit FIXED_D_PRIORITY = 1'b0
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     i_pmem_read,
   input  logic     i_pmem_write,
   input  lc3b_word i_pmem_address,
   input  lc3b_line i_pmem_wdata,
   output lc3b_line i_pmem_rdata,
   output logic     i_pmem_resp,
   input  logic     d_pmem_read,
   input  logic     d_pmem_write,
   input  lc3b_word d_pmem_address,
   input  lc3b_line d_pmem_wdata,
   output lc3b_line d_pmem_rdata,
   output logic     d_pmem_resp,
   output logic     pmem_read,
   output logic     pmem_write,
   output lc3b_word pmem_address,
   output lc3b_line pmem_wdata,
   input  lc3b_line pmem_rdata,
   input  logic     pmem_resp
);

   arb_state_t state_q;
   arb_sel_t   last_grant_q;
   arb_sel_t   sel;
   logic       active;
   logic       i_pending;
   logic       d_pending;

   assign i_pending = i_pmem_read | i_pmem_write;
   assign d_pending = d_pmem_read | d_pmem_write;

   // Outputs are forced low while rst is held, even before the state register clears.
   assign active = ~rst && (state_q != IDLE);
   assign sel    = (state_q == SERVE_D) ? SEL_D : SEL_I;

   assign i_pmem_resp  = ~rst && (state_q == SERVE_I) && pmem_resp;
   assign d_pmem_resp  = ~rst && (state_q == SERVE_D) && pmem_resp;
   assign i_pmem_rdata = rst ? '0 : pmem_rdata;
   assign d_pmem_rdata = rst ? '0 : pmem_rdata;

   cache_arbiter_mux u_mux (
      .en        (active),
      .sel       (sel),
      .i_read    (i_pmem_read),
      .i_write   (i_pmem_write),
      .i_address (i_pmem_address),
      .i_wdata   (i_pmem_wdata),
      .d_read    (d_pmem_read),
      .d_write   (d_pmem_write),
      .d_address (d_pmem_address),
      .d_wdata   (d_pmem_wdata),
      .read      (pmem_read),
      .write     (pmem_write),
      .address   (pmem_address),
      .wdata     (pmem_wdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= SEL_D;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_pending && d_pending) begin
                  state_q <= (FIXED_D_PRIORITY || last_grant_q == SEL_I) ? SERVE_D : SERVE_I;
               end else if (i_pending) begin
                  state_q <= SERVE_I;
               end else if (d_pending) begin
                  state_q <= SERVE_D;
               end
            end
            SERVE_I: begin
               // Completion takes precedence over an abandon in the same cycle.
               if (pmem_resp) begin
                  state_q      <= IDLE;
                  last_grant_q <= SEL_I;
               end else if (!i_pending) begin
                  state_q <= IDLE;
               end
            end
            SERVE_D: begin
               if (pmem_resp) begin
                  state_q      <= IDLE;
                  last_grant_q <= SEL_D;
               end else if (!d_pending) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed vector bench for cache_arbiter: round-robin and fixed-D-priority instances.
import cache_arbiter_pkg::*;

module tb_cache_arbiter;

   localparam lc3b_line I_LINE = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam lc3b_line D_LINE = 128'hdddd_0001_dddd_0002_dddd_0003_dddd_0004;
   localparam lc3b_line RDATA  = 128'hcafe_f00d_0123_4567_89ab_cdef_beef_5a5a;

   logic     clk = 1'b0;
   logic     rst = 1'b0;
   logic     i_pmem_read = 1'b0, i_pmem_write = 1'b0;
   lc3b_word i_pmem_address = '0;
   lc3b_line i_pmem_wdata = I_LINE;
   logic     d_pmem_read = 1'b0, d_pmem_write = 1'b0;
   lc3b_word d_pmem_address = '0;
   lc3b_line d_pmem_wdata = D_LINE;
   lc3b_line pmem_rdata = RDATA;
   logic     pmem_resp = 1'b0;
   logic     fx_pmem_resp = 1'b0;

   lc3b_line i_pmem_rdata, d_pmem_rdata, pmem_wdata;
   logic     i_pmem_resp, d_pmem_resp, pmem_read, pmem_write;
   lc3b_word pmem_address;
   lc3b_line fx_i_rdata, fx_d_rdata, fx_wdata;
   logic     fx_i_resp, fx_d_resp, fx_read, fx_write;
   lc3b_word fx_address;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   cache_arbiter #(.FIXED_D_PRIORITY(1'b0)) dut (
      .clk(clk), .rst(rst),
      .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
      .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
      .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   cache_arbiter #(.FIXED_D_PRIORITY(1'b1)) dut_fx (
      .clk(clk), .rst(rst),
      .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
      .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
      .i_pmem_rdata(fx_i_rdata), .i_pmem_resp(fx_i_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(fx_d_rdata), .d_pmem_resp(fx_d_resp),
      .pmem_read(fx_read), .pmem_write(fx_write),
      .pmem_address(fx_address), .pmem_wdata(fx_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(fx_pmem_resp)
   );

   typedef struct packed {
      logic        rst;
      logic        ird;
      logic        iwr;
      logic [15:0] iaddr;
      logic        drd;
      logic        dwr;
      logic [15:0] daddr;
      logic        resp;
      logic        erd;
      logic        ewr;
      logic [15:0] eaddr;
      logic [1:0]  ewsel;   // 0: zero, 1: I line, 2: D line
      logic        eiresp;
      logic        edresp;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic r, input logic ird, input logic iwr,
                               input logic [15:0] ia, input logic drd, input logic dwr,
                               input logic [15:0] da, input logic rsp, input logic erd,
                               input logic ewr, input logic [15:0] ea, input logic [1:0] ews,
                               input logic eir, input logic edr);
      vec_t v;
      v = '{r, ird, iwr, ia, drd, dwr, da, rsp, erd, ewr, ea, ews, eir, edr};
      return v;
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic apply(input vec_t v);
      rst            = v.rst;
      i_pmem_read    = v.ird;
      i_pmem_write   = v.iwr;
      i_pmem_address = v.iaddr;
      d_pmem_read    = v.drd;
      d_pmem_write   = v.dwr;
      d_pmem_address = v.daddr;
      pmem_resp      = v.resp;
      fx_pmem_resp   = 1'b0;
   endtask

   task automatic run_alt();
      logic [3:0] rr_order, fx_order;
      int         rr_n, fx_n;
      rr_order = '0; fx_order = '0; rr_n = 0; fx_n = 0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      i_pmem_read = 1'b1; i_pmem_write = 1'b0; i_pmem_address = 16'h0a00;
      d_pmem_read = 1'b1; d_pmem_write = 1'b0; d_pmem_address = 16'h0d00;
      for (int cyc = 0; cyc < 40 && (rr_n < 4 || fx_n < 4); cyc++) begin
         // Memory model: answer in the first cycle a strobe is seen.
         pmem_resp    = pmem_read | pmem_write;
         fx_pmem_resp = fx_read | fx_write;
         @(negedge clk);
         if (rr_n < 4 && (i_pmem_resp || d_pmem_resp)) begin
            rr_order[rr_n] = d_pmem_resp;
            rr_n++;
         end
         if (fx_n < 4 && (fx_i_resp || fx_d_resp)) begin
            fx_order[fx_n] = fx_d_resp;
            fx_n++;
         end
         @(posedge clk); #1;
      end
      pmem_resp = 1'b0; fx_pmem_resp = 1'b0;
      i_pmem_read = 1'b0; d_pmem_read = 1'b0;
      check("rr_grant_count", 256'(rr_n), 256'(4));
      check("fx_grant_count", 256'(fx_n), 256'(4));
      // Bit k is 1 when grant k went to D: RR gives I,D,I,D; fixed gives D,D,D,D.
      check("rr_grant_order", 256'(rr_order), 256'(4'b1010));
      check("fx_grant_order", 256'(fx_order), 256'(4'b1111));
   endtask

   initial begin
      // Reset with requests and a stray resp present: outputs stay 0.
      vq.push_back(mk(1, 1,0,16'h1230, 0,1,16'h8000, 1, 0,0,16'h0,0,0,0));
      // Lone I read, resp on the third serve cycle.
      vq.push_back(mk(0, 0,0,16'h0,    0,0,16'h0,    0, 0,0,16'h0,0,0,0));
      vq.push_back(mk(0, 1,0,16'h1230, 0,0,16'h0,    0, 0,0,16'h0,0,0,0));
      vq.push_back(mk(0, 1,0,16'h1230, 0,0,16'h0,    0, 1,0,16'h1230,1,0,0));
      vq.push_back(mk(0, 1,0,16'h1230, 0,0,16'h0,    0, 1,0,16'h1230,1,0,0));
      vq.push_back(mk(0, 1,0,16'h1230, 0,0,16'h0,    1, 1,0,16'h1230,1,1,0));
      vq.push_back(mk(0, 0,0,16'h0,    0,0,16'h0,    0, 0,0,16'h0,0,0,0));
      // Abandoned D read (last grant I); following contention must still go to D.
      vq.push_back(mk(0, 0,0,16'h0,    1,0,16'h3000, 0, 0,0,16'h0,0,0,0));
      vq.push_back(mk(0, 0,0,16'h0,    1,0,16'h3000, 0, 1,0,16'h3000,2,0,0));
      vq.push_back(mk(0, 0,0,16'h0,    0,0,16'h3000, 0, 0,0,16'h3000,2,0,0));
      vq.push_back(mk(0, 1,0,16'h0500, 1,0,16'h3000, 0, 0,0,16'h0,0,0,0));
      vq.push_back(mk(0, 1,0,16'h0500, 1,0,16'h3000, 1, 1,0,16'h3000,2,0,1));
      vq.push_back(mk(0, 1,0,16'h0500, 0,0,16'h0,    0, 0,0,16'h0,0,0,0));
      vq.push_back(mk(0, 1,0,16'h0500, 0,0,16'h0,    1, 1,0,16'h0500,1,1,0));
      vq.push_back(mk(0, 0,0,16'h0,    0,0,16'h0,    0, 0,0,16'h0,0,0,0));
      // Reset, then simultaneous I read / D write: I first, D two cycles after I's resp.
      vq.push_back(mk(1, 0,0,16'h0,    0,0,16'h0,    0, 0,0,16'h0,0,0,0));
      vq.push_back(mk(0, 1,0,16'h0040, 0,1,16'h8000, 0, 0,0,16'h0,0,0,0));
      vq.push_back(mk(0, 1,0,16'h0040, 0,1,16'h8ff0, 0, 1,0,16'h0040,1,0,0));
      vq.push_back(mk(0, 1,0,16'h0040, 1,1,16'h8000, 1, 1,0,16'h0040,1,1,0));
      vq.push_back(mk(0, 0,0,16'h0,    0,1,16'h8000, 0, 0,0,16'h0,0,0,0));
      vq.push_back(mk(0, 0,0,16'h0,    0,1,16'h8000, 1, 0,1,16'h8000,2,0,1));
      vq.push_back(mk(0, 0,0,16'h0,    0,0,16'h0,    0, 0,0,16'h0,0,0,0));
      // D read+write together: write wins, read masked.
      vq.push_back(mk(0, 0,0,16'h0,    1,1,16'h2000, 0, 0,0,16'h0,0,0,0));
      vq.push_back(mk(0, 0,0,16'h0,    1,1,16'h2000, 0, 0,1,16'h2000,2,0,0));
      vq.push_back(mk(0, 0,0,16'h0,    1,1,16'h2000, 1, 0,1,16'h2000,2,0,1));
      vq.push_back(mk(0, 0,0,16'h0,    0,0,16'h0,    0, 0,0,16'h0,0,0,0));
      // I write is honoured.
      vq.push_back(mk(0, 0,1,16'h7000, 0,0,16'h0,    0, 0,0,16'h0,0,0,0));
      vq.push_back(mk(0, 0,1,16'h7000, 0,0,16'h0,    1, 0,1,16'h7000,1,1,0));
      vq.push_back(mk(0, 0,0,16'h0,    0,0,16'h0,    0, 0,0,16'h0,0,0,0));
      // Reset two cycles into a D read; late resp is discarded; I then served.
      vq.push_back(mk(0, 0,0,16'h0,    1,0,16'h4000, 0, 0,0,16'h0,0,0,0));
      vq.push_back(mk(0, 0,0,16'h0,    1,0,16'h4000, 0, 1,0,16'h4000,2,0,0));
      vq.push_back(mk(0, 0,0,16'h0,    1,0,16'h4000, 0, 1,0,16'h4000,2,0,0));
      vq.push_back(mk(1, 0,0,16'h0,    1,0,16'h4000, 0, 0,0,16'h0,0,0,0));
      vq.push_back(mk(0, 0,0,16'h0,    0,0,16'h0,    1, 0,0,16'h0,0,0,0));
      vq.push_back(mk(0, 1,0,16'h6000, 0,0,16'h0,    0, 0,0,16'h0,0,0,0));
      vq.push_back(mk(0, 1,0,16'h6000, 0,0,16'h0,    1, 1,0,16'h6000,1,1,0));
      vq.push_back(mk(0, 0,0,16'h0,    0,0,16'h0,    0, 0,0,16'h0,0,0,0));

      @(posedge clk); #1;
      for (int i = 0; i < vq.size(); i++) begin
         lc3b_line exp_w, exp_r;
         apply(vq[i]);
         exp_w = (vq[i].ewsel == 2'd1) ? I_LINE : (vq[i].ewsel == 2'd2) ? D_LINE : '0;
         exp_r = vq[i].rst ? '0 : RDATA;
         @(negedge clk);
         check($sformatf("vec%0d_ctl", i),
               256'({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address}),
               256'({vq[i].erd, vq[i].ewr, vq[i].eiresp, vq[i].edresp, vq[i].eaddr}));
         check($sformatf("vec%0d_wdata", i), 256'(pmem_wdata), 256'(exp_w));
         check($sformatf("vec%0d_rdata", i), {i_pmem_rdata, d_pmem_rdata}, {exp_r, exp_r});
         @(posedge clk); #1;
      end

      run_alt();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
